// File: rtl/fft_pkg.sv
// Shared definitions for the memory-based radix-2 DIT FFT sequencer.
package fft_pkg;

    localparam int LOG2N_DEF = 4;
    localparam int N_DEF     = 1 << LOG2N_DEF;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOAD        = 3'd1,
        CALC        = 3'd2,
        STAGE_DRAIN = 3'd3,
        UNLOAD      = 3'd4,
        DONE        = 3'd5
    } fft_state_t;

    // Reverses the low w bits of v. Bits at position w and above come back as zero.
    function automatic logic [15:0] bitrev(input logic [15:0] v, input int w);
        logic [15:0] r;
        r = '0;
        for (int b = 0; b < 16; b++) begin
            if (b < w) r[b] = v[w-1-b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Butterfly address generator: maps stage s and butterfly index k to the two
// RAM leg addresses and the twiddle ROM address. Purely combinational.
module fft_bf_addr_gen #(
    parameter int LOG2N = 4
) (
    input  logic [LOG2N-1:0] s,
    input  logic [LOG2N-2:0] k,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw
);

    logic [LOG2N-1:0] kx;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] tw_shift;

    assign kx       = {1'b0, k};
    assign half     = LOG2N'(1) << s;
    assign pos      = kx & (half - LOG2N'(1));
    assign tw_shift = LOG2N'(LOG2N - 1) - s;

    // Group base is (k / half) * 2 * half; the leg offset within the group is pos.
    assign addr_a = (((kx >> s) << s) << 1) | pos;
    assign addr_b = addr_a + half;

    // pos < half <= N/2, so it always fits the narrower ROM address.
    assign tw = pos[LOG2N-2:0] << tw_shift;

endmodule

// File: rtl/fft_seq_ctrl.sv
// Frame sequencer for the in-place radix-2 DIT FFT core: bit-reversed load,
// LOG2N butterfly stages with a write-back drain, and natural-order unload.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting for start
// LOAD        | accepting N samples into bit-reversed RAM addresses
// CALC        | issuing N/2 butterflies of stage s, one per cycle
// STAGE_DRAIN | BF_LAT quiet cycles so the stage's last write-back lands
// UNLOAD      | presenting RAM addresses 0..N-1 to the downstream reader
// DONE        | one-cycle completion pulse
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N  = LOG2N_DEF,
    parameter int BF_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ld_we,
    output logic [LOG2N-1:0] ld_addr,
    output logic             bf_en,
    output logic [LOG2N-1:0] bf_addr_a,
    output logic [LOG2N-1:0] bf_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wb_en,
    output logic [LOG2N-1:0] wb_addr_a,
    output logic [LOG2N-1:0] wb_addr_b,
    output logic [LOG2N-1:0] stage,
    output logic [LOG2N-1:0] rd_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam logic [LOG2N-1:0] LAST_S     = LOG2N'(LOG2N - 1);
    localparam logic [2:0]       DRAIN_LOAD = 3'(BF_LAT - 1);

    fft_state_t       state;
    logic [LOG2N-1:0] i_cnt;
    logic [LOG2N-2:0] k_cnt;
    logic [LOG2N-1:0] s_cnt;
    logic [LOG2N-1:0] r_cnt;
    logic [2:0]       drain_cnt;

    logic [15:0]      ld_rev;
    logic             unused_rev;
    logic [LOG2N-1:0] gen_a;
    logic [LOG2N-1:0] gen_b;
    logic [LOG2N-2:0] gen_tw;

    logic             dl_en [BF_LAT];
    logic [LOG2N-1:0] dl_a  [BF_LAT];
    logic [LOG2N-1:0] dl_b  [BF_LAT];

    fft_bf_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .s      (s_cnt),
        .k      (k_cnt),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw     (gen_tw)
    );

    assign ld_rev     = bitrev(16'(i_cnt), LOG2N);
    assign unused_rev = ^ld_rev[15:LOG2N];
    assign ld_addr    = ld_rev[LOG2N-1:0];
    assign ld_we      = in_valid & in_ready;

    // Butterfly addresses are forced to zero whenever no butterfly is issued,
    // so the RAM/ROM ports and the write-back line stay quiet between stages.
    assign bf_addr_a = bf_en ? gen_a  : '0;
    assign bf_addr_b = bf_en ? gen_b  : '0;
    assign tw_addr   = bf_en ? gen_tw : '0;

    assign stage    = s_cnt;
    assign rd_addr  = r_cnt;
    assign out_last = out_valid & (r_cnt == '1);

    assign wb_en     = dl_en[BF_LAT-1];
    assign wb_addr_a = dl_a[BF_LAT-1];
    assign wb_addr_b = dl_b[BF_LAT-1];

    // Frame sequencing FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            i_cnt     <= '0;
            k_cnt     <= '0;
            s_cnt     <= '0;
            r_cnt     <= '0;
            drain_cnt <= '0;
            in_ready  <= 1'b0;
            bf_en     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        i_cnt    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (i_cnt == '1) begin
                            state    <= CALC;
                            i_cnt    <= '0;
                            in_ready <= 1'b0;
                            bf_en    <= 1'b1;
                            s_cnt    <= '0;
                            k_cnt    <= '0;
                        end else begin
                            i_cnt <= i_cnt + 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (k_cnt == '1) begin
                        state     <= STAGE_DRAIN;
                        bf_en     <= 1'b0;
                        drain_cnt <= DRAIN_LOAD;
                    end else begin
                        k_cnt <= k_cnt + 1'b1;
                    end
                end
                STAGE_DRAIN: begin
                    if (drain_cnt == '0) begin
                        k_cnt <= '0;
                        if (s_cnt == LAST_S) begin
                            state     <= UNLOAD;
                            s_cnt     <= '0;
                            r_cnt     <= '0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= CALC;
                            s_cnt <= s_cnt + 1'b1;
                            bf_en <= 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        if (r_cnt == '1) begin
                            state     <= DONE;
                            r_cnt     <= '0;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    bf_en     <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    // Write-back delay line; free-running so late write-backs still land after
    // CALC ends, cleared only by reset so an aborted frame leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < BF_LAT; j++) begin
                dl_en[j] <= 1'b0;
                dl_a[j]  <= '0;
                dl_b[j]  <= '0;
            end
        end else begin
            dl_en[0] <= bf_en;
            dl_a[0]  <= bf_addr_a;
            dl_b[0]  <= bf_addr_b;
            for (int j = 1; j < BF_LAT; j++) begin
                dl_en[j] <= dl_en[j-1];
                dl_a[j]  <= dl_a[j-1];
                dl_b[j]  <= dl_b[j-1];
            end
        end
    end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_fft_seq_ctrl;

    localparam int LOG2N     = 4;
    localparam int N         = 16;
    localparam int BF_LAT    = 2;
    localparam int STAGE_CYC = N / 2 + BF_LAT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, ld_we, bf_en, wb_en, out_valid, out_last, busy, done;
    logic [3:0] ld_addr, bf_addr_a, bf_addr_b, wb_addr_a, wb_addr_b, stage, rd_addr;
    logic [2:0] tw_addr;

    fft_seq_ctrl #(
        .LOG2N  (LOG2N),
        .BF_LAT (BF_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .bf_en     (bf_en),
        .bf_addr_a (bf_addr_a),
        .bf_addr_b (bf_addr_b),
        .tw_addr   (tw_addr),
        .wb_en     (wb_en),
        .wb_addr_a (wb_addr_a),
        .wb_addr_b (wb_addr_b),
        .stage     (stage),
        .rd_addr   (rd_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int tw;
        int st;
        int off;
    } bf_exp_t;

    typedef struct {
        int addr;
        int last;
    } out_exp_t;

    int       ld_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int       rdy_pat [4] = '{1, 0, 0, 1};
    // hand-computed butterfly points: s, k, a, b, tw
    int       hand_tab [3][5] = '{'{0, 0, 0, 1, 0}, '{1, 3, 5, 7, 4}, '{3, 5, 5, 13, 5}};

    int       ld_q [$];
    bf_exp_t  bf_q [$];
    bf_exp_t  wb_q [$];
    out_exp_t out_q [$];

    int       compared = 0;
    int       mismatched = 0;
    int       cyc = 0;
    bit       mon_en = 1'b0;
    bit       t0_set = 1'b0;
    bit       uv_seen = 1'b0;
    int       t0 = 0;
    int       exp_done = -1;
    bf_exp_t  be;
    out_exp_t oe;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, int'({in_ready, ld_we, bf_en, wb_en, out_valid, out_last, busy, done}), 0);
        chk({tag, "_addr1"}, int'({ld_addr, bf_addr_a, bf_addr_b, tw_addr}), 0);
        chk({tag, "_addr2"}, int'({wb_addr_a, wb_addr_b, stage, rd_addr}), 0);
    endtask

    // Monitor: compares every presented output against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (in_valid || in_ready || ld_we)
                chk("ld_we_gate", int'(ld_we), int'(in_valid & in_ready));
            if (ld_we) begin
                if (ld_q.size() == 0) chk("ld_extra", 1, 0);
                else chk("ld_addr", int'(ld_addr), ld_q.pop_front());
            end
            if (bf_en) begin
                if (!t0_set) begin
                    t0     = cyc;
                    t0_set = 1'b1;
                end
                if (bf_q.size() == 0) chk("bf_extra", 1, 0);
                else begin
                    be = bf_q.pop_front();
                    chk("bf_addr_a", int'(bf_addr_a), be.a);
                    chk("bf_addr_b", int'(bf_addr_b), be.b);
                    chk("tw_addr", int'(tw_addr), be.tw);
                    chk("stage", int'(stage), be.st);
                    chk("bf_time", cyc - t0, be.off);
                end
            end
            if (wb_en) begin
                if (wb_q.size() == 0) chk("wb_extra", 1, 0);
                else begin
                    be = wb_q.pop_front();
                    chk("wb_addr_a", int'(wb_addr_a), be.a);
                    chk("wb_addr_b", int'(wb_addr_b), be.b);
                    chk("wb_time", cyc - t0, be.off + BF_LAT);
                end
            end
            if (out_valid) begin
                if (!uv_seen) begin
                    uv_seen = 1'b1;
                    chk("unload_entry", cyc - t0, LOG2N * STAGE_CYC);
                    chk("stage_in_unload", int'(stage), 0);
                end
                if (out_q.size() == 0) chk("out_extra", 1, 0);
                else begin
                    oe = out_q[0];
                    chk("rd_addr", int'(rd_addr), oe.addr);
                    chk("out_last", int'(out_last), oe.last);
                    if (out_ready) begin
                        void'(out_q.pop_front());
                        if (oe.last != 0) exp_done = cyc + 1;
                    end
                end
            end else if (out_last) begin
                chk("out_last_stray", int'(out_last), 0);
            end
            if (done || cyc == exp_done)
                chk("done_pulse", int'(done), int'(cyc == exp_done));
        end
    end

    task automatic push_frame();
        bf_exp_t e;
        out_exp_t o;
        int half;
        for (int n = 0; n < N; n++) ld_q.push_back(ld_tab[n]);
        for (int s = 0; s < LOG2N; s++) begin
            for (int k = 0; k < N / 2; k++) begin
                half = 1 << s;
                e.a   = (k / half) * 2 * half + (k % half);
                e.b   = e.a + half;
                e.tw  = (k % half) * ((N / 2) / half);
                e.st  = s;
                e.off = s * STAGE_CYC + k;
                for (int h = 0; h < 3; h++) begin
                    if (hand_tab[h][0] == s && hand_tab[h][1] == k) begin
                        e.a  = hand_tab[h][2];
                        e.b  = hand_tab[h][3];
                        e.tw = hand_tab[h][4];
                    end
                end
                bf_q.push_back(e);
                wb_q.push_back(e);
            end
        end
        for (int r = 0; r < N; r++) begin
            o.addr = r;
            o.last = (r == N - 1) ? 1 : 0;
            out_q.push_back(o);
        end
    endtask

    task automatic run_frame(input int gap, input bit poke_start, input bit toggle_rdy);
        bit seen_done;
        push_frame();
        t0_set   = 1'b0;
        uv_seen  = 1'b0;
        exp_done = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 0; n < N; n++) begin
            if (n > 0 && gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            if (poke_start && n == 6) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_after_load", int'(in_ready), 0);
        chk("calc_entry", int'(bf_en), 1);
        seen_done = 1'b0;
        for (int c = 0; c < 400 && !seen_done; c++) begin
            out_ready = toggle_rdy ? rdy_pat[c % 4][0] : 1'b1;
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        out_ready = 1'b0;
        if (!seen_done) chk("frame_timeout", 0, 1);
        if (poke_start) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_in_ready", int'(in_ready), 0);
        chk("ld_q_empty", ld_q.size(), 0);
        chk("bf_q_empty", bf_q.size(), 0);
        chk("wb_q_empty", wb_q.size(), 0);
        chk("out_q_empty", out_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset_idle");

        mon_en = 1'b1;
        run_frame(0, 1'b1, 1'b1);
        run_frame(3, 1'b0, 1'b0);
        mon_en = 1'b0;

        // Abort a frame mid-CALC at s=2, k=3.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        in_valid = 1'b1;
        repeat (N) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("abort_calc_start", int'(bf_en), 1);
        repeat (2 * STAGE_CYC + 3) begin
            @(posedge clk); #1;
        end
        chk("abort_stage", int'(stage), 2);
        chk("abort_addr_a", int'(bf_addr_a), 3);
        chk("abort_addr_b", int'(bf_addr_b), 7);
        chk("abort_tw", int'(tw_addr), 6);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_abort");
        @(negedge clk);
        chk_all_zero("abort_next");
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < BF_LAT + 2; c++) begin
            @(negedge clk);
            chk("abort_no_wb", int'(wb_en), 0);
            chk("abort_idle_busy", int'(busy), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fft_seq_ctrl.md
Name: fft_seq_ctrl

Overview:
- Sequencer for the in-place, memory-based radix-2 DIT FFT core.
- Steps through four phases per frame, all addresses for a single dual-port sample RAM:
  - load N input samples into bit-reversed addresses;
  - issue LOG2N stages of butterflies with twiddle-ROM addresses;
  - track butterfly write-back through the datapath pipeline;
  - stream results out in natural order.
- Sits between the top-level frame handshake and the RAM, butterfly unit and twiddle ROM.

Parameters:
- LOG2N, 4, log2 of FFT length; N = 2^LOG2N (default 16-point).
- BF_LAT, 2, butterfly datapath latency in cycles from bf_en to write-back; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame start request; sampled only in IDLE.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller accepts input sample.
- ld_we  out  1  RAM write enable for load (= in_valid & in_ready).
- ld_addr  out  LOG2N  bit-reversed load address.
- bf_en  out  1  butterfly issue strobe; RAM read of bf_addr_a/b this cycle.
- bf_addr_a  out  LOG2N  butterfly upper-leg address.
- bf_addr_b  out  LOG2N  butterfly lower-leg address.
- tw_addr  out  LOG2N-1  twiddle ROM address.
- wb_en  out  1  butterfly write-back strobe (bf_en delayed BF_LAT).
- wb_addr_a  out  LOG2N  bf_addr_a delayed BF_LAT.
- wb_addr_b  out  LOG2N  bf_addr_b delayed BF_LAT.
- stage  out  LOG2N bits, holds 0..LOG2N-1  current stage index.
- rd_addr  out  LOG2N  unload read address, natural order.
- out_valid  in/out: out  1  rd_addr valid for unload.
- out_ready  in  1  downstream accepts unload sample.
- out_last  out  1  asserted with out_valid when rd_addr = N-1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset: state IDLE; all counters and delay lines 0. Every output is 0, including in_ready, bf_en, wb_en, out_valid, busy and done. Reset asserted mid-frame aborts immediately; the pipeline delay line is cleared, so no stray wb_en occurs.
- IDLE:
  - start=1 → LOAD; load counter i=0.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1.
  - Each in_valid cycle writes ld_addr = bitrev(i) and increments i.
  - i=N-1 accepted → CALC with s=0, k=0.
  - in_valid=0 stalls with no side effects.
- CALC:
  - bf_en=1 every cycle.
  - k counts 0..N/2-1. half = 2^s; pos = k & (half-1).
  - bf_addr_a = ((k>>s)<<(s+1)) | pos; bf_addr_b = bf_addr_a + half.
  - tw_addr = pos << (LOG2N-1-s).
  - Address outputs are combinational from registered s, k.
  - k = N/2-1 → STAGE_DRAIN.
- STAGE_DRAIN:
  - bf_en=0; wait exactly BF_LAT cycles so the last write-back lands (RAW hazard).
  - If s<LOG2N-1: s++, k=0, → CALC.
  - Otherwise → UNLOAD with r=0.
- Write-back delay line: BF_LAT-deep shift register of {bf_en, bf_addr_a, bf_addr_b}. It drives wb_en and wb_addr_a/b, runs in all states, and clears only on reset.
- Compute cycle count per frame: LOG2N*(N/2+BF_LAT), which is 40 at the defaults.
- UNLOAD:
  - out_valid=1; rd_addr=r.
  - r increments only when out_valid & out_ready.
  - out_last = (r = N-1).
  - Transfer at r=N-1 → DONE.
  - out_ready=0 holds rd_addr stable.
- DONE: done=1 for one cycle, busy=1 in this cycle, then → IDLE. A start asserted during DONE is ignored.
- stage holds s, and holds 0 outside CALC/STAGE_DRAIN.
- All counters are exact width. No wrap occurs inside a phase, because terminal counts are detected before wrap.

Decomposition:
- fft_pkg:
  - LOG2N / N defaults;
  - state encoding constants IDLE, LOAD, CALC, STAGE_DRAIN, UNLOAD, DONE (3-bit);
  - bit-reverse function.
- Sub-module fft_bf_addr_gen: purely combinational s,k → bf_addr_a, bf_addr_b, tw_addr. It is reused by the verification reference model.

Test Plan:
- Reset during CALC with s=2, k=3 → next cycle: IDLE, all outputs 0, no wb_en in the following BF_LAT cycles.
- start, then 16 consecutive in_valid → ld_addr sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; in_ready drops after the 16th; next state CALC.
- CALC address checks:
  - s=0, k=0 → a=0, b=1, tw=0;
  - s=1, k=3 → a=5, b=7, tw=4;
  - s=3, k=5 → a=5, b=13, tw=5;
  - wb_en/wb_addr echo each issue exactly 2 cycles later.
- Stage timing:
  - 8 bf_en cycles, then 2 idle cycles, per stage;
  - first bf_en to UNLOAD entry = 40 cycles;
  - no bf_en of stage s+1 before the last wb_en of stage s.
- UNLOAD with out_ready toggling 1,0,0,1,…:
  - rd_addr holds during the 0 cycles;
  - values 0..15 appear in order;
  - out_last only with rd_addr=15;
  - done pulses once, one cycle after the final transfer.
- Protocol robustness:
  - start pulsed during LOAD and DONE → ignored, frame unaffected;
  - in_valid gaps of 3 cycles during LOAD → ld_addr sequence unchanged, ld_we only on valid cycles.
